fec_interleaver: RTL

Transmit-side block interleaver for the modem FEC chain. It sits between the LDPC encoder output and the symbol mapper, and is the exact inverse of the receive-side de-interleaver. It accepts one 2304-bit codeword as a serial bit stream written row-wise into a ROWS x COLS matrix, then emits the same bits column-wise. Ping-pong buffering lets one codeword be written while the previous one is read.

---
 rtl/fec_interleaver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fec_interleaver.sv
// fec_interleaver: ping-pong block interleaver, row-wise in, column-wise out.
// Two N-bit banks: the writer fills bank wb while the reader drains bank rb.
module fec_interleaver #(
  parameter int ROWS = 36,
  parameter int COLS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic isop,
  input  logic ival,
  input  logic idat,
  output logic ordy,
  input  logic irdy,
  output logic oval,
  output logic odat,
  output logic osop,
  output logic oeop
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [AW-1:0] ADR_END = AW'(N - 1);
  localparam logic [AW-1:0] ADR_STEP = AW'(COLS);
  localparam logic [RW-1:0] ROW_END = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_END = CW'(COLS - 1);

  typedef enum logic {W_IDLE, W_FILL} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_DRAIN, R_LAST} rd_t;

  logic mem [2][N];
  logic [1:0] full;
  logic wb, rb;

  wst_t ws, ws_n;
  logic [AW-1:0] wr_cnt, waddr;
  logic acc, we, wr_last;

  rd_t rs, rs_n;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] radr;
  logic adv, k_first, k_last;
  logic issue, free, rbank;

  assign ordy = !full[wb];
  assign acc  = ival && ordy;

  always_ff @(posedge clk or negedge rst)
    if (!rst) ws <= W_IDLE;
    else      ws <= ws_n;

  always_comb begin
    ws_n = ws;
    unique case (ws)
      W_IDLE:  if (acc && isop) ws_n = W_FILL;
      W_FILL:  if (wr_last) ws_n = W_IDLE;
      default: ws_n = W_IDLE;
    endcase
  end

  // isop always restarts at address 0, dropping any partial codeword
  always_comb begin
    we      = acc && (isop || ws == W_FILL);
    waddr   = (isop || ws == W_IDLE) ? '0 : wr_cnt;
    wr_last = we && !isop && ws == W_FILL && wr_cnt == ADR_END;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_cnt <= '0;
      wb     <= 1'b0;
    end else if (we) begin
      wr_cnt <= wr_last ? '0 : waddr + 1'b1;
      if (wr_last) wb <= !wb;
    end

  always_ff @(posedge clk)
    if (we) mem[wb][waddr] <= idat;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      full <= '0;
    end else begin
      if (wr_last) full[wb] <= 1'b1;
      if (free)    full[rb] <= 1'b0;
    end

  assign adv     = !oval || irdy;
  assign k_first = row == '0 && col == '0;
  assign k_last  = row == ROW_END && col == COL_END;

  always_ff @(posedge clk or negedge rst)
    if (!rst) rs <= R_IDLE;
    else      rs <= rs_n;

  always_comb begin
    rs_n = rs;
    unique case (rs)
      R_IDLE:  if (full[rb]) rs_n = R_DRAIN;
      R_DRAIN: if (issue && k_last) rs_n = R_LAST;
      R_LAST:
        if (free)
          rs_n = !issue ? R_IDLE : k_last ? R_LAST : R_DRAIN;
      default: rs_n = R_IDLE;
    endcase
  end

  // in R_LAST the eop bit is pending; the next bank starts on its transfer
  always_comb begin
    issue = 1'b0;
    free  = 1'b0;
    rbank = rb;
    unique case (rs)
      R_DRAIN: issue = adv;
      R_LAST: begin
        free  = oval && irdy;
        rbank = !rb;
        issue = free && full[!rb];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rb   <= 1'b0;
      row  <= '0;
      col  <= '0;
      radr <= '0;
    end else begin
      if (free) rb <= !rb;
      if (issue) begin
        if (k_last) begin
          row  <= '0;
          col  <= '0;
          radr <= '0;
        end else if (row == ROW_END) begin
          row  <= '0;
          col  <= col + 1'b1;
          radr <= AW'(col) + AW'(1);
        end else begin
          row  <= row + 1'b1;
          radr <= radr + ADR_STEP;
        end
      end
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      oval <= 1'b0;
      odat <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
    end else if (issue) begin
      oval <= 1'b1;
      odat <= mem[rbank][radr];
      osop <= k_first;
      oeop <= k_last;
    end else if (irdy) begin
      oval <= 1'b0;
      osop <= 1'b0;
      oeop <= 1'b0;
    end
endmodule
